// File: rtl/alu_pipe_pkg.sv
// Shared types and helpers for the pipelined ARM data-processing ALU.
// Opcode encoding, flag bit positions and opcode class predicates.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'h0,
        OP_EOR = 4'h1,
        OP_SUB = 4'h2,
        OP_RSB = 4'h3,
        OP_ADD = 4'h4,
        OP_ADC = 4'h5,
        OP_SBC = 4'h6,
        OP_RSC = 4'h7,
        OP_TST = 4'h8,
        OP_TEQ = 4'h9,
        OP_CMP = 4'hA,
        OP_CMN = 4'hB,
        OP_ORR = 4'hC,
        OP_MOV = 4'hD,
        OP_BIC = 4'hE,
        OP_MVN = 4'hF
    } opcode_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Comparisons only produce flags, never a register write.
    function automatic logic is_compare(opcode_e op);
        return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
    endfunction

    // Logical ops keep the old C and V.
    function automatic logic is_logical(opcode_e op);
        return op inside {OP_AND, OP_EOR, OP_TST, OP_TEQ,
                          OP_ORR, OP_MOV, OP_BIC, OP_MVN};
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Request/result/flags bundle between decode, ALU and writeback.
// Optional ALU_PIPE_QFLAG_EN adds the sticky QFlag and its QClear.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             InValid;
    logic             InReady;
    logic [3:0]       OpCode;
    logic             SetFlags;
    logic [WIDTH-1:0] Op1;
    logic [WIDTH-1:0] Op2;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Out;
    logic             WriteEn;
    logic             NFlag;
    logic             ZFlag;
    logic             CFlag;
    logic             VFlag;
    logic             FlagsWrEn;
    logic [3:0]       FlagsIn;
`ifdef ALU_PIPE_QFLAG_EN
    logic             QFlag;
    logic             QClear;

    modport master (
        output InValid, OpCode, SetFlags, Op1, Op2,
        output OutReady, FlagsWrEn, FlagsIn, QClear,
        input  InReady, OutValid, Out, WriteEn,
        input  NFlag, ZFlag, CFlag, VFlag, QFlag
    );

    modport slave (
        input  InValid, OpCode, SetFlags, Op1, Op2,
        input  OutReady, FlagsWrEn, FlagsIn, QClear,
        output InReady, OutValid, Out, WriteEn,
        output NFlag, ZFlag, CFlag, VFlag, QFlag
    );
`else
    modport master (
        output InValid, OpCode, SetFlags, Op1, Op2,
        output OutReady, FlagsWrEn, FlagsIn,
        input  InReady, OutValid, Out, WriteEn,
        input  NFlag, ZFlag, CFlag, VFlag
    );

    modport slave (
        input  InValid, OpCode, SetFlags, Op1, Op2,
        input  OutReady, FlagsWrEn, FlagsIn,
        output InReady, OutValid, Out, WriteEn,
        output NFlag, ZFlag, CFlag, VFlag
    );
`endif
endinterface

// File: rtl/alu_pipe_core.sv
// Combinational ARM data-processing ALU, WIDTH bits wide.
// Arithmetic runs at WIDTH+1 bits; subtraction uses a + ~b + cin.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       OpCode,
    input  logic [WIDTH-1:0] Op1,
    input  logic [WIDTH-1:0] Op2,
    input  logic             CIn,
    input  logic             COld,
    input  logic             VOld,
    output logic [WIDTH-1:0] Out,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             WriteEn
);
    opcode_e          op;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_c;
    logic [WIDTH-1:0] lres;
    logic [WIDTH:0]   sum;
    logic             arith;

    assign op = opcode_e'(OpCode);

    // Select adder operands/carry-in and the logical result per opcode.
    always_comb begin
        add_a = '0;
        add_b = '0;
        add_c = 1'b0;
        lres  = '0;
        unique case (op)
            OP_SUB, OP_CMP: begin
                add_a = Op1; add_b = ~Op2; add_c = 1'b1;
            end
            OP_RSB: begin
                add_a = Op2; add_b = ~Op1; add_c = 1'b1;
            end
            OP_ADD, OP_CMN: begin
                add_a = Op1; add_b = Op2;
            end
            OP_ADC: begin
                add_a = Op1; add_b = Op2; add_c = CIn;
            end
            OP_SBC: begin
                add_a = Op1; add_b = ~Op2; add_c = CIn;
            end
            OP_RSC: begin
                add_a = Op2; add_b = ~Op1; add_c = CIn;
            end
            OP_AND, OP_TST: lres = Op1 & Op2;
            OP_EOR, OP_TEQ: lres = Op1 ^ Op2;
            OP_ORR:         lres = Op1 | Op2;
            OP_MOV:         lres = Op2;
            OP_BIC:         lres = Op1 & ~Op2;
            OP_MVN:         lres = ~Op2;
            default:        lres = '0;
        endcase
    end

    assign sum   = {1'b0, add_a} + {1'b0, add_b}
                 + {{WIDTH{1'b0}}, add_c};
    assign arith = !is_logical(op);

    assign Out = arith ? sum[WIDTH-1:0] : lres;
    assign N   = Out[WIDTH-1];
    assign Z   = (Out == '0);
    assign C   = arith ? sum[WIDTH] : COld;
    assign V   = arith ? ((add_a[WIDTH-1] == add_b[WIDTH-1])
                       && (sum[WIDTH-1] != add_a[WIDTH-1]))
                       : VOld;
    assign WriteEn = !is_compare(op);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: E operand stage, then output register.
// Holds the NZCV flags; ALU_PIPE_QFLAG_EN adds a sticky QFlag.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     Clk,
    input  logic     Reset,
    alu_pipe_if.slave bus
);
    logic             e_valid_q, e_valid_d;
    logic [3:0]       e_op_q;
    logic             e_set_q;
    logic [WIDTH-1:0] e_op1_q;
    logic [WIDTH-1:0] e_op2_q;
    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] o_out_q;
    logic             o_we_q;
    logic [3:0]       flags_q, flags_d;
    logic             advance;
    logic             accept;
    logic             upd_flags;
    logic [WIDTH-1:0] c_out;
    logic             c_n, c_z, c_c, c_v, c_we;

    assign advance = e_valid_q && (!o_valid_q || bus.OutReady);
    assign bus.InReady = !e_valid_q || advance;
    assign accept  = bus.InValid && bus.InReady;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .OpCode  (e_op_q),
        .Op1     (e_op1_q),
        .Op2     (e_op2_q),
        .CIn     (flags_q[FLAG_C]),
        .COld    (flags_q[FLAG_C]),
        .VOld    (flags_q[FLAG_V]),
        .Out     (c_out),
        .N       (c_n),
        .Z       (c_z),
        .C       (c_c),
        .V       (c_v),
        .WriteEn (c_we)
    );

    assign upd_flags = advance
                    && (e_set_q || is_compare(opcode_e'(e_op_q)));

    // Next-state for valids and flags; MSR load beats the op update.
    always_comb begin
        e_valid_d = e_valid_q;
        o_valid_d = o_valid_q;
        flags_d   = flags_q;
        if (bus.InReady)
            e_valid_d = bus.InValid;
        if (advance)
            o_valid_d = 1'b1;
        else if (bus.OutReady)
            o_valid_d = 1'b0;
        if (bus.FlagsWrEn)
            flags_d = bus.FlagsIn;
        else if (upd_flags)
            flags_d = {c_n, c_z, c_c, c_v};
    end

    // Pipeline and flag state; reset empties both stages.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            e_valid_q <= 1'b0;
            e_op_q    <= '0;
            e_set_q   <= 1'b0;
            e_op1_q   <= '0;
            e_op2_q   <= '0;
            o_valid_q <= 1'b0;
            o_out_q   <= '0;
            o_we_q    <= 1'b0;
            flags_q   <= '0;
        end else begin
            e_valid_q <= e_valid_d;
            o_valid_q <= o_valid_d;
            flags_q   <= flags_d;
            if (accept) begin
                e_op_q  <= bus.OpCode;
                e_set_q <= bus.SetFlags;
                e_op1_q <= bus.Op1;
                e_op2_q <= bus.Op2;
            end
            if (advance) begin
                o_out_q <= c_out;
                o_we_q  <= c_we;
            end
        end
    end

`ifdef ALU_PIPE_QFLAG_EN
    logic qflag_q;

    // Sticky overflow: any arithmetic op with V leaving E sets it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            qflag_q <= 1'b0;
        else if (bus.FlagsWrEn && bus.QClear)
            qflag_q <= 1'b0;
        else if (advance && !is_logical(opcode_e'(e_op_q)) && c_v)
            qflag_q <= 1'b1;
    end

    assign bus.QFlag = qflag_q;
`endif

    assign bus.OutValid = o_valid_q;
    assign bus.Out      = o_out_q;
    assign bus.WriteEn  = o_we_q;
    assign bus.NFlag    = flags_q[FLAG_N];
    assign bus.ZFlag    = flags_q[FLAG_Z];
    assign bus.CFlag    = flags_q[FLAG_C];
    assign bus.VFlag    = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=32 and WIDTH=8.
// Expected values are hand-computed constants.
module tb_alu_pipe;
    import alu_pkg::*;

    logic Clk = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_pipe_if #(.WIDTH(32)) b32 ();
    alu_pipe_if #(.WIDTH(8))  b8 ();

    alu_pipe #(.WIDTH(32)) dut32 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (b32.slave)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (b8.slave)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send32(input logic [3:0] op, input logic s,
                          input logic [31:0] a, input logic [31:0] b);
        b32.InValid  = 1'b1;
        b32.OpCode   = op;
        b32.SetFlags = s;
        b32.Op1      = a;
        b32.Op2      = b;
    endtask

    task automatic send8(input logic [3:0] op, input logic s,
                         input logic [7:0] a, input logic [7:0] b);
        b8.InValid  = 1'b1;
        b8.OpCode   = op;
        b8.SetFlags = s;
        b8.Op1      = a;
        b8.Op2      = b;
    endtask

    function automatic logic [3:0] fl32();
        return {b32.NFlag, b32.ZFlag, b32.CFlag, b32.VFlag};
    endfunction

    function automatic logic [3:0] fl8();
        return {b8.NFlag, b8.ZFlag, b8.CFlag, b8.VFlag};
    endfunction

    initial begin
        Reset = 1'b1;
        b32.InValid = 1'b0; b32.OpCode = '0; b32.SetFlags = 1'b0;
        b32.Op1 = '0; b32.Op2 = '0; b32.OutReady = 1'b1;
        b32.FlagsWrEn = 1'b0; b32.FlagsIn = '0;
        b8.InValid = 1'b0; b8.OpCode = '0; b8.SetFlags = 1'b0;
        b8.Op1 = '0; b8.Op2 = '0; b8.OutReady = 1'b1;
        b8.FlagsWrEn = 1'b0; b8.FlagsIn = '0;
`ifdef ALU_PIPE_QFLAG_EN
        b32.QClear = 1'b0;
        b8.QClear  = 1'b0;
`endif
        #1;
        check("rst_inready_during", b32.InReady, 1);
        tick(); tick();
        check("rst_outvalid", b32.OutValid, 0);
        check("rst_out", b32.Out, 0);
        check("rst_we", b32.WriteEn, 0);
        check("rst_flags", fl32(), 4'b0000);
        Reset = 1'b0;
        #1;
        check("rst_inready_after", b32.InReady, 1);

        // ADD overflow, S=1
        send32(OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
        tick();
        b32.InValid = 1'b0;
        check("add_lat_e", b32.OutValid, 0);
        tick();
        check("add_valid", b32.OutValid, 1);
        check("add_out", b32.Out, 32'h8000_0000);
        check("add_flags", fl32(), 4'b1001);
        check("add_we", b32.WriteEn, 1);
        tick();
        check("add_drain", b32.OutValid, 0);

        // CMP 5,5 then ADC 1,2 back to back
        send32(OP_CMP, 1'b0, 32'd5, 32'd5);
        tick();
        send32(OP_ADC, 1'b0, 32'd1, 32'd2);
        tick();
        b32.InValid = 1'b0;
        check("cmp_valid", b32.OutValid, 1);
        check("cmp_we", b32.WriteEn, 0);
        check("cmp_out", b32.Out, 0);
        check("cmp_flags", fl32(), 4'b0110);
        tick();
        check("adc_out", b32.Out, 32'd4);
        check("adc_we", b32.WriteEn, 1);
        check("adc_flags_kept", fl32(), 4'b0110);
        tick();

        // MSR then SUB 0,1 with S=0
        b32.FlagsWrEn = 1'b1;
        b32.FlagsIn   = 4'b0100;
        tick();
        b32.FlagsWrEn = 1'b0;
        check("msr_flags", fl32(), 4'b0100);
        send32(OP_SUB, 1'b0, 32'd0, 32'd1);
        tick();
        b32.InValid = 1'b0;
        tick();
        check("sub_out", b32.Out, 32'hFFFF_FFFF);
        check("sub_flags_kept", fl32(), 4'b0100);
        tick();

        // Backpressure: three ops offered, consumer stalled
        b32.OutReady = 1'b0;
        send32(OP_ADD, 1'b0, 32'd1, 32'd1);
        tick();
        send32(OP_ADD, 1'b0, 32'd2, 32'd2);
        check("stall_rdy_2nd", b32.InReady, 1);
        tick();
        send32(OP_ADD, 1'b0, 32'd3, 32'd3);
        check("stall_rdy_full", b32.InReady, 0);
        check("stall_out_a", b32.Out, 32'd2);
        tick();
        check("stall_rdy_hold", b32.InReady, 0);
        check("stall_valid_hold", b32.OutValid, 1);
        check("stall_out_hold", b32.Out, 32'd2);
        tick();
        check("stall_out_hold2", b32.Out, 32'd2);
        b32.OutReady = 1'b1;
        #1;
        check("stall_rdy_comb", b32.InReady, 1);
        tick();
        b32.InValid = 1'b0;
        check("stall_out_b", b32.Out, 32'd4);
        tick();
        check("stall_out_c", b32.Out, 32'd6);
        check("stall_valid_c", b32.OutValid, 1);
        tick();
        check("stall_drain", b32.OutValid, 0);
        check("stall_flags_kept", fl32(), 4'b0100);

        // Reset with both stages full
        b32.FlagsWrEn = 1'b1;
        b32.FlagsIn   = 4'b1010;
        tick();
        b32.FlagsWrEn = 1'b0;
        b32.OutReady  = 1'b0;
        send32(OP_ADD, 1'b0, 32'd1, 32'd1);
        tick();
        send32(OP_ADD, 1'b0, 32'd2, 32'd2);
        tick();
        b32.InValid = 1'b0;
        check("mid_full_valid", b32.OutValid, 1);
        check("mid_full_rdy", b32.InReady, 0);
        check("mid_flags_pre", fl32(), 4'b1010);
        #1 Reset = 1'b1;
        #1;
        check("mid_rst_valid", b32.OutValid, 0);
        check("mid_rst_flags", fl32(), 4'b0000);
        check("mid_rst_rdy", b32.InReady, 1);
        tick();
        Reset = 1'b0;
        b32.OutReady = 1'b1;
        send32(OP_ADD, 1'b0, 32'd3, 32'd4);
        tick();
        b32.InValid = 1'b0;
        check("post_rst_lat", b32.OutValid, 0);
        tick();
        check("post_rst_valid", b32.OutValid, 1);
        check("post_rst_out", b32.Out, 32'd7);
        tick();
        check("post_rst_drain", b32.OutValid, 0);

        // WIDTH=8: FlagsIn beats the op flag update
        send8(OP_ADD, 1'b1, 8'hFF, 8'h01);
        tick();
        b8.InValid   = 1'b0;
        b8.FlagsWrEn = 1'b1;
        b8.FlagsIn   = 4'b0001;
        tick();
        b8.FlagsWrEn = 1'b0;
        check("w8_valid", b8.OutValid, 1);
        check("w8_out", b8.Out, 8'h00);
        check("w8_flags_msr", fl8(), 4'b0001);
        tick();
        send8(OP_ADD, 1'b1, 8'h7F, 8'h01);
        tick();
        b8.InValid = 1'b0;
        tick();
        check("w8_ovf_out", b8.Out, 8'h80);
        check("w8_ovf_flags", fl8(), 4'b1001);
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
